// File: rtl/pipelined_vector_addsub.sv
// Two-stage valid/ready pipelined signed vector add/subtract with per-component overflow flags.
// Define PIPELINED_VECTOR_ADDSUB_SATURATE_EN to clamp overflowing components instead of wrapping.
module pipelined_vector_addsub #(
    parameter int unsigned COMP_WIDTH = 19,
    parameter int unsigned NUM_COMP   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sub,
    input  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector_1,
    input  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector_2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_COMP*COMP_WIDTH-1:0] out_vector,
    output logic [NUM_COMP-1:0]            out_ovf
);

    localparam int unsigned W  = COMP_WIDTH;
    localparam int unsigned VW = NUM_COMP * COMP_WIDTH;

    logic          ready_q;
    logic          s1_valid_q;
    logic          s1_sub_q;
    logic [VW-1:0] s1_a_q;
    logic [VW-1:0] s1_b_q;
    logic          s2_valid_q;
    logic [VW-1:0] s2_vec_q;
    logic [NUM_COMP-1:0] s2_ovf_q;

    logic          s1_adv;
    logic          s2_adv;
    logic          accept;
    logic [VW-1:0] s2_vec_d;
    logic [NUM_COMP-1:0] s2_ovf_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    // ready_q keeps in_ready low during reset and until the first edge after release.
    assign in_ready = ready_q && s1_adv;
    assign accept   = in_valid && in_ready;

    assign out_valid  = s2_valid_q;
    assign out_vector = s2_vec_q;
    assign out_ovf    = s2_ovf_q;

    always_comb begin : calc
        logic [W:0]   a_ext;
        logic [W:0]   b_ext;
        logic [W:0]   b_eff;
        logic [W:0]   sum;
        logic         ovf;
        logic [W-1:0] res;
        s2_vec_d = '0;
        s2_ovf_d = '0;
        for (int i = 0; i < NUM_COMP; i++) begin
            a_ext = {s1_a_q[i*W+W-1], s1_a_q[i*W +: W]};
            b_ext = {s1_b_q[i*W+W-1], s1_b_q[i*W +: W]};
            b_eff = s1_sub_q ? ~b_ext : b_ext;
            sum   = a_ext + b_eff + {{W{1'b0}}, s1_sub_q};
            ovf   = sum[W] ^ sum[W-1];
`ifdef PIPELINED_VECTOR_ADDSUB_SATURATE_EN
            if (ovf) begin
                res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                res = sum[W-1:0];
            end
`else
            res = sum[W-1:0];
`endif
            s2_vec_d[i*W +: W] = res;
            s2_ovf_d[i]        = ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Data registers load only under their valid bit so idle-cycle X never reaches state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sub_q <= in_sub;
                s1_a_q   <= in_vector_1;
                s1_b_q   <= in_vector_2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_vec_q   <= '0;
            s2_ovf_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_vec_q <= s2_vec_d;
                s2_ovf_q <= s2_ovf_d;
            end
        end
    end

endmodule

// File: doc/pipelined_vector_addsub.md
Name: pipelined_vector_addsub

Overview:
Parametrised, pipelined successor to the combinational signed vector adder used in the ray-tracing datapath. It adds or subtracts two packed signed vectors, one mode select per transaction, for ray/hit-point arithmetic such as origin + t·dir and hit − origin. The block sits between the intersection and shading stages and uses a valid/ready handshake on both sides so it can stall under downstream backpressure. It also reports overflow per component.

Parameters:
COMP_WIDTH, 19, width in bits of one signed two's-complement component
NUM_COMP, 3, number of components per vector

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, asynchronous and active-high
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept an input this cycle
in_sub  input  1  0 = vec1 + vec2, 1 = vec1 − vec2
in_vector_1  input  NUM_COMP*COMP_WIDTH  packed operand 1
in_vector_2  input  NUM_COMP*COMP_WIDTH  packed operand 2
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_vector  output  NUM_COMP*COMP_WIDTH  packed result
out_ovf  output  NUM_COMP  per-component signed overflow flag, bit i for component i

Behaviour:
- Packing: component i occupies bits [(i+1)*COMP_WIDTH−1 : i*COMP_WIDTH]. Component NUM_COMP−1 (x) is at the MSB end.
- Reset: asynchronous and active-high. While rst is high:
  - out_valid=0, out_vector=0, out_ovf=0.
  - Both stage valid bits are 0.
  - in_ready=0.
  After rst deasserts, in_ready=1 from the first clock edge.
- Pipeline has two register stages:
  - S1 captures operands and in_sub.
  - S2 holds the computed result and flags, and drives the out_* ports.
- Transfer rules:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- Latency and throughput: an accepted input appears on out_valid on the 2nd rising edge after acceptance, provided there is no stall. Steady-state throughput is one vector per cycle.
- Stage advance:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational; no combinational path from in_valid).
- Stall: while out_valid=1 and out_ready=0, out_vector and out_ovf hold stable. S1 holds if it is full. Up to 2 vectors are buffered, after which in_ready=0.
- Simultaneous accept and issue: when an input is accepted and an output is consumed in the same cycle while full, no data is lost or duplicated.
- Arithmetic is per component, in COMP_WIDTH+1 bits with sign extension:
  - Subtract computes a + ~b + 1.
  - ovf_i = (bit COMP_WIDTH of the result) XOR (bit COMP_WIDTH−1 of the result).
- Result:
  - Default: the low COMP_WIDTH bits (wrap-around), matching the original adder's modulo behaviour.
  - Subtracting −2^(W−1) is handled correctly (overflow flagged).
- out_ovf is always produced, independent of the optional feature.
- Reset asserted mid-stream: all in-flight vectors are discarded and outputs return to reset values immediately (asynchronous), without waiting for a clock edge.
- in_vector_* and in_sub are don't-care when in_valid=0. No X may propagate into state while the corresponding valid bit is 0 gating it.

Optional Feature:
Macro: PIPELINED_VECTOR_ADDSUB_SATURATE_EN.
- Defined: each overflowing component saturates.
  - Positive overflow (sign bit COMP_WIDTH of the extended result = 0) gives 2^(W−1)−1.
  - Negative overflow gives −2^(W−1).
  - out_ovf is still reported.
  - Latency is unchanged (the clamp sits in the S2 input logic).
- Undefined: wrap-around result as above, with no clamp logic.

Test Plan:
Use defaults W=19, N=3.
1. All-ones + all-ones (−1 + −1), in_sub=0 -> each component 0x7FFFE, out_ovf=000, out_valid exactly 2 cycles after accept.
2. 0x3FFFF + 0x00001 in every component -> wrap build: 0x40000, out_ovf=111; SATURATE_EN build: 0x3FFFF, out_ovf=111.
3. in_sub=1, vec1=0, vec2=0x40000 in every component -> wrap build: 0x40000, ovf=111; SATURATE_EN build: 0x3FFFF; vec1=5, vec2=3 gives 0x00002, ovf=000.
4. Stream 5 back-to-back vectors with out_ready low for cycles 2–4 -> in_ready drops after 2 buffered, out_vector stable during stall, all 5 results delivered in order with none lost or duplicated.
5. Mixed mode: alternate in_sub 0/1 every cycle with out_ready=1 -> each result matches its own transaction's mode, one result per cycle.
6. Assert rst asynchronously between edges while 2 vectors are in flight -> out_valid=0, out_vector=0 and in_ready=0 immediately; after release, in_ready=1 and the first new input emerges 2 cycles after acceptance.
